// File: rtl/kbd_event_scanner.sv
// Keyboard front end: debounces key inputs, scans for press/release edges and queues 8-bit
// event codes in a FWFT FIFO. Define KBD_ENC_EN to add quadrature encoder detent events.
module kbd_event_scanner #(
  parameter int unsigned N_KEYS     = 32,
  parameter int unsigned DIV        = 5500,
  parameter int unsigned DEB_TICKS  = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned N_ENC      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_KEYS-1:0]             keys_in,
  input  logic [N_ENC-1:0]              enc_a,
  input  logic [N_ENC-1:0]              enc_b,
  output logic                          ev_valid,
  output logic [7:0]                    ev_code,
  input  logic                          ev_ready,
  output logic [$clog2(FIFO_DEPTH):0]   ev_level,
  output logic                          ovf,
  input  logic                          ovf_clr
);

  localparam int unsigned CW = $clog2(DIV);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic {S_IDLE, S_SCAN} scan_state_t;

  logic [CW-1:0]     div_q, div_d;
  logic              tick;
  logic [N_KEYS-1:0] k1_q, k2_q;
  logic [N_KEYS-1:0] sample_q, sample_d;
  logic [7:0]        deb_q, deb_d;
  logic              armed_q, armed_d;
  logic              cpend_q, cpend_d;
  logic              commit_take;

  scan_state_t       state_q, state_d;
  logic [5:0]        idx_q, idx_d;
  logic [N_KEYS-1:0] stable_q, stable_d;
  logic [N_KEYS-1:0] rep_q, rep_d;
  logic [63:0]       diff64, stable64;
  logic              key_push;
  logic [7:0]        key_code;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]     level_q, level_d;
  logic              full, pop, push;
  logic [7:0]        push_code;

  logic              enc_push;
  logic [7:0]        enc_code;

  // prescaler and debounce
  always_comb begin
    tick        = (div_q == CW'(DIV - 1));
    div_d       = tick ? '0 : div_q + CW'(1);
    commit_take = cpend_q && (state_q == S_IDLE);
    sample_d    = sample_q;
    deb_d       = deb_q;
    armed_d     = armed_q;
    cpend_d     = cpend_q;
    if (commit_take) cpend_d = 1'b0;
    if (tick) begin
      sample_d = k2_q;
      if (k2_q != sample_q) begin
        deb_d   = '0;
        armed_d = 1'b1;
      end else if (armed_q) begin
        deb_d = deb_q + 8'd1;
        if (deb_q + 8'd1 == 8'(DEB_TICKS - 1)) begin
          cpend_d = 1'b1;
          armed_d = 1'b0;
        end
      end
    end
  end

  // scanner: one key index per clk, stalls on full FIFO or encoder push
  always_comb begin
    diff64                 = '0;
    diff64[N_KEYS-1:0]     = stable_q ^ rep_q;
    stable64               = '0;
    stable64[N_KEYS-1:0]   = stable_q;
    state_d  = state_q;
    idx_d    = idx_q;
    stable_d = stable_q;
    rep_d    = rep_q;
    key_push = 1'b0;
    key_code = '0;
    case (state_q)
      S_IDLE: begin
        if (commit_take) begin
          stable_d = sample_q;
          idx_d    = '0;
          state_d  = S_SCAN;
        end
      end
      S_SCAN: begin
        if (!(full || enc_push)) begin
          if (diff64[idx_q]) begin
            key_push = 1'b1;
            key_code = {(stable64[idx_q] ? 2'b10 : 2'b01), idx_q};
            rep_d    = rep_q ^ (N_KEYS'(1) << idx_q);
          end
          if (idx_q == 6'(N_KEYS - 1)) state_d = S_IDLE;
          else                         idx_d   = idx_q + 6'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO (first-word-fall-through)
  always_comb begin
    full      = (level_q == LW'(FIFO_DEPTH));
    ev_valid  = (level_q != '0);
    ev_level  = level_q;
    ev_code   = ev_valid ? mem_q[rd_q] : '0;
    pop       = ev_valid && ev_ready;
    push      = enc_push || key_push;
    push_code = enc_push ? enc_code : key_code;
    wr_d      = wr_q + AW'(push);
    rd_d      = rd_q + AW'(pop);
    level_d   = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_code;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q    <= '0;
      k1_q     <= '1;
      k2_q     <= '1;
      sample_q <= '1;
      deb_q    <= '0;
      armed_q  <= 1'b0;
      cpend_q  <= 1'b0;
      state_q  <= S_IDLE;
      idx_q    <= '0;
      stable_q <= '1;
      rep_q    <= '1;
      wr_q     <= '0;
      rd_q     <= '0;
      level_q  <= '0;
    end else begin
      div_q    <= div_d;
      k1_q     <= keys_in;
      k2_q     <= k1_q;
      sample_q <= sample_d;
      deb_q    <= deb_d;
      armed_q  <= armed_d;
      cpend_q  <= cpend_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      stable_q <= stable_d;
      rep_q    <= rep_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      level_q  <= level_d;
    end
  end

`ifdef KBD_ENC_EN
  logic [N_ENC-1:0]  ea1_q, ea2_q, eb1_q, eb2_q;
  logic [1:0]        eprev_q [N_ENC];
  logic [1:0]        eprev_d [N_ENC];
  logic [2:0]        acc_q   [N_ENC];
  logic [2:0]        acc_d   [N_ENC];
  logic [N_ENC-1:0]  epend_q, epend_d, edir_q, edir_d, served;
  logic              ovf_q, ovf_d, found, ovf_set;

  // +1 for 00->01->11->10->00, -1 for the reverse, 0 for no or double-bit change
  function automatic logic [1:0] gray_step(input logic [1:0] p, input logic [1:0] c);
    case ({p, c})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: return 2'b01;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: return 2'b11;
      default:                            return 2'b00;
    endcase
  endfunction

  always_comb begin
    found    = 1'b0;
    served   = '0;
    enc_code = '0;
    epend_d  = epend_q;
    edir_d   = edir_q;
    ovf_set  = 1'b0;
    for (int unsigned e = 0; e < N_ENC; e++) begin
      if (epend_q[e] && !found) begin
        found      = 1'b1;
        served[e]  = 1'b1;
        epend_d[e] = 1'b0;
        enc_code   = {2'b11, edir_q[e], 1'b0, 4'(e)};
      end
    end
    enc_push = found && !full;
    if (found && full) ovf_set = 1'b1;
    for (int unsigned e = 0; e < N_ENC; e++) begin
      logic [1:0] cur, st;
      logic [3:0] sum;
      cur        = {ea2_q[e], eb2_q[e]};
      st         = gray_step(eprev_q[e], cur);
      sum        = {acc_q[e][2], acc_q[e]} + {{2{st[1]}}, st};
      eprev_d[e] = eprev_q[e];
      acc_d[e]   = acc_q[e];
      if (tick) begin
        eprev_d[e] = cur;
        acc_d[e]   = sum[2:0];
        if (sum == 4'b0100 || sum == 4'b1100) begin
          acc_d[e]   = '0;
          if (epend_q[e] && !served[e]) ovf_set = 1'b1;
          epend_d[e] = 1'b1;
          edir_d[e]  = sum[3];
        end
      end
    end
    ovf_d = (ovf_q && !ovf_clr) || ovf_set;
    ovf   = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ea1_q   <= '0;
      ea2_q   <= '0;
      eb1_q   <= '0;
      eb2_q   <= '0;
      epend_q <= '0;
      edir_q  <= '0;
      ovf_q   <= 1'b0;
      for (int unsigned e = 0; e < N_ENC; e++) begin
        eprev_q[e] <= '0;
        acc_q[e]   <= '0;
      end
    end else begin
      ea1_q   <= enc_a;
      ea2_q   <= ea1_q;
      eb1_q   <= enc_b;
      eb2_q   <= eb1_q;
      epend_q <= epend_d;
      edir_q  <= edir_d;
      ovf_q   <= ovf_d;
      for (int unsigned e = 0; e < N_ENC; e++) begin
        eprev_q[e] <= eprev_d[e];
        acc_q[e]   <= acc_d[e];
      end
    end
  end
`else
  logic unused_enc;
  assign unused_enc = ^{enc_a, enc_b, ovf_clr};
  assign enc_push   = 1'b0;
  assign enc_code   = '0;
  assign ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_kbd_event_scanner.sv
// Directed bench for kbd_event_scanner (DIV=4, DEB_TICKS=3, FIFO_DEPTH=2); encoder cases need KBD_ENC_EN.
module tb_kbd_event_scanner;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] keys_in;
  logic [3:0]  enc_a, enc_b;
  logic        ev_valid;
  logic [7:0]  ev_code;
  logic        ev_ready;
  logic [1:0]  ev_level;
  logic        ovf;
  logic        ovf_clr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  kbd_event_scanner #(
    .N_KEYS(32), .DIV(4), .DEB_TICKS(3), .FIFO_DEPTH(2), .N_ENC(4)
  ) dut (
    .clk(clk), .rst(rst), .keys_in(keys_in), .enc_a(enc_a), .enc_b(enc_b),
    .ev_valid(ev_valid), .ev_code(ev_code), .ev_ready(ev_ready),
    .ev_level(ev_level), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  typedef struct {
    logic [31:0] keys;
    int          n;
    logic [7:0]  c0;
    logic [7:0]  c1;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Holds ev_ready high and checks the next n accepted codes in order.
  task automatic expect_stream(input string nm, input int n,
                               input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    logic [7:0] ex [3];
    logic [7:0] c;
    logic       got;
    int         t;
    ex[0] = e0; ex[1] = e1; ex[2] = e2;
    ev_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (!ev_valid && t < 200) begin
        @(negedge clk);
        t++;
      end
      got = ev_valid;
      c   = ev_code;
      chk($sformatf("%s_arrive%0d", nm, k), 32'(got), 32'd1);
      if (got) chk($sformatf("%s_code%0d", nm, k), 32'(c), 32'(ex[k]));
      @(negedge clk);
    end
    ev_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    wait_clk(3);
    rst = 1'b1;
  endtask

`ifdef KBD_ENC_EN
  task automatic enc_step(input int e, input logic a, input logic b);
    enc_a[e] = a;
    enc_b[e] = b;
    wait_clk(12);
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{32'hFFFF_FFFF, 0, 8'h00, 8'h00};
    vt[1] = '{32'hFFFF_FFDF, 1, 8'h45, 8'h00};
    vt[2] = '{32'hFFFF_FFFF, 1, 8'h85, 8'h00};
    vt[3] = '{32'h7FFF_FFFE, 2, 8'h40, 8'h5F};
    vt[4] = '{32'hFFFF_FFFF, 2, 8'h80, 8'h9F};
    vt[5] = '{32'hFFFF_EF7F, 2, 8'h47, 8'h4C};
    vt[6] = '{32'hFFFF_EFFF, 1, 8'h87, 8'h00};
    vt[7] = '{32'hFFFF_FFFF, 1, 8'h8C, 8'h00};

    rst = 1'b0; keys_in = '1; enc_a = '0; enc_b = '0; ev_ready = 1'b0; ovf_clr = 1'b0;
    wait_clk(3);
    chk("rst_valid", 32'(ev_valid), 0);
    chk("rst_level", 32'(ev_level), 0);
    chk("rst_code",  32'(ev_code), 0);
    chk("rst_ovf",   32'(ovf), 0);
    rst = 1'b1;
    wait_clk(80);
    chk("idle_valid", 32'(ev_valid), 0);
    chk("idle_level", 32'(ev_level), 0);

    for (int i = 0; i < 8; i++) begin
      keys_in = vt[i].keys;
      wait_clk(120);
      chk($sformatf("vec%0d_level", i), 32'(ev_level), 32'(vt[i].n));
      if (vt[i].n > 0) expect_stream($sformatf("vec%0d", i), vt[i].n, vt[i].c0, vt[i].c1, 8'h00);
      wait_clk(2);
      chk($sformatf("vec%0d_drained", i), 32'(ev_level), 0);
    end

    for (int k = 0; k < 10; k++) begin
      keys_in[2] = (k % 2 == 0) ? 1'b0 : 1'b1;
      wait_clk(4);
      chk("bounce_quiet", 32'(ev_level), 0);
    end
    keys_in[2] = 1'b0;
    wait_clk(120);
    chk("bounce_level", 32'(ev_level), 1);
    expect_stream("bounce_press", 1, 8'h42, 8'h00, 8'h00);
    keys_in[2] = 1'b1;
    wait_clk(120);
    expect_stream("bounce_release", 1, 8'h82, 8'h00, 8'h00);

    keys_in = 32'h7FFF_FFF6;
    wait_clk(150);
    chk("stall_level", 32'(ev_level), 2);
    chk("stall_head", 32'(ev_code), 32'h40);
    wait_clk(40);
    chk("stall_hold_level", 32'(ev_level), 2);
    chk("stall_hold_head", 32'(ev_code), 32'h40);
    expect_stream("stall_press", 3, 8'h40, 8'h43, 8'h5F);
    chk("stall_ovf", 32'(ovf), 0);
    wait_clk(2);
    chk("stall_drained", 32'(ev_level), 0);
    keys_in = '1;
    wait_clk(150);
    expect_stream("stall_release", 3, 8'h80, 8'h83, 8'h9F);

    keys_in = 32'h7FFF_FFF6;
    wait_clk(150);
    chk("midscan_level", 32'(ev_level), 2);
    rst = 1'b0;
    @(negedge clk);
    chk("midscan_rst_valid", 32'(ev_valid), 0);
    chk("midscan_rst_level", 32'(ev_level), 0);
    chk("midscan_rst_code",  32'(ev_code), 0);
    rst = 1'b1;
    expect_stream("rescan_press", 3, 8'h40, 8'h43, 8'h5F);
    keys_in = '1;
    wait_clk(150);
    expect_stream("rescan_release", 3, 8'h80, 8'h83, 8'h9F);
    wait_clk(2);
    chk("rescan_drained", 32'(ev_level), 0);

`ifdef KBD_ENC_EN
    enc_step(1, 1'b0, 1'b1); enc_step(1, 1'b1, 1'b1); enc_step(1, 1'b1, 1'b0); enc_step(1, 1'b0, 1'b0);
    expect_stream("enc_cw", 1, 8'hC1, 8'h00, 8'h00);
    enc_step(1, 1'b1, 1'b0); enc_step(1, 1'b1, 1'b1); enc_step(1, 1'b0, 1'b1); enc_step(1, 1'b0, 1'b0);
    expect_stream("enc_ccw", 1, 8'hE1, 8'h00, 8'h00);
    chk("enc_ovf_clean", 32'(ovf), 0);

    keys_in = 32'hFFFF_FFF6;
    wait_clk(150);
    chk("enc_full_level", 32'(ev_level), 2);
    enc_step(1, 1'b0, 1'b1); enc_step(1, 1'b1, 1'b1); enc_step(1, 1'b1, 1'b0); enc_step(1, 1'b0, 1'b0);
    wait_clk(20);
    chk("enc_drop_ovf", 32'(ovf), 1);
    chk("enc_drop_level", 32'(ev_level), 2);
    chk("enc_drop_head", 32'(ev_code), 32'h40);
    wait_clk(20);
    chk("enc_ovf_sticky", 32'(ovf), 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("enc_ovf_clr", 32'(ovf), 0);
    expect_stream("enc_keys", 2, 8'h40, 8'h43, 8'h00);
    keys_in = '1;
    wait_clk(150);
    expect_stream("enc_keys_rel", 2, 8'h80, 8'h83, 8'h00);
    wait_clk(2);
    chk("enc_drained", 32'(ev_level), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
